// File: rtl/mux_pkg.sv
// Shared constants, output-state encoding and the index-width helper
// used by the round-robin N-to-1 mux.
package mux_pkg;

  localparam int DEF_N = 8;
  localparam int DEF_W = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Ceiling log2, evaluated at elaboration time for index widths.
  function automatic int log2_f(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority search: grants the first requester after ptr,
// wrapping modulo N, and only while en is high.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int SW = log2_f(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx
);

  logic [SW-1:0] w_idx;
  logic          w_found;

  // N is a power of two, so adding to ptr in SW bits wraps for free
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_idx     = '0;
    w_found   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      w_idx = ptr + SW'(i);
      if (en && !w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
        w_found      = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/rr_mux_nx1.sv
// N-to-1 valid/ready mux with fixed-select or round-robin channel choice
// and a single registered output stage.
module rr_mux_nx1
  import mux_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rr_en,
  input  logic [log2_f(N)-1:0]      sel,
  input  logic [N*W-1:0]            in_data,
  input  logic [N-1:0]              in_valid,
  output logic [N-1:0]              in_ready,
  output logic [W-1:0]              out_data,
  output logic [log2_f(N)-1:0]      out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int SW = log2_f(N);

  out_state_e    r_state;
  out_state_e    w_state_nxt;
  logic [SW-1:0] r_ptr;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_ch;

  logic          w_load;
  logic          w_rr_en;
  logic [N-1:0]  w_rr_grant;
  logic [SW-1:0] w_rr_idx;
  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_grant_idx;
  logic          w_xfer;
  logic [W-1:0]  w_ch_data [N];

  for (genvar k = 0; k < N; k++) begin : g_unpack
    assign w_ch_data[k] = in_data[k*W +: W];
  end

  assign w_load  = (r_state == ST_EMPTY) || out_ready;
  assign w_rr_en = w_load && !rst && rr_en;

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req       (in_valid),
    .ptr       (r_ptr),
    .en        (w_rr_en),
    .grant     (w_rr_grant),
    .grant_idx (w_rr_idx)
  );

  // Grant selection; mode and sel act on the grant in the same cycle
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    if (rst || !w_load) begin
      w_grant = '0;
    end else if (rr_en) begin
      w_grant     = w_rr_grant;
      w_grant_idx = w_rr_idx;
    end else if (in_valid[sel]) begin
      w_grant[sel] = 1'b1;
      w_grant_idx  = sel;
    end else begin
      w_grant = '0;
    end
  end

  assign w_xfer    = |w_grant;
  assign in_ready  = w_grant;
  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

  // Output-stage next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: w_state_nxt = w_xfer ? ST_FULL : ST_EMPTY;
      ST_FULL: begin
        if (w_xfer) begin
          w_state_nxt = ST_FULL;
        end else if (out_ready) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // State, pointer and output registers; ptr starts at N-1 so channel 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_ptr      <= SW'(N - 1);
      r_out_data <= '0;
      r_out_ch   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_out_data <= w_ch_data[w_grant_idx];
        r_out_ch   <= w_grant_idx;
      end
      if (w_xfer && rr_en) begin
        r_ptr <= w_rr_idx;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_nx1.sv
// Scoreboard bench for rr_mux_nx1 (N=8, W=8): a reference grant model pushes
// expected beats on input transfers and pops them as the output drains.
module tb_rr_mux_nx1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rr_en;
  logic [2:0]  sel;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] sb [$];
  int          glog [$];
  int          m_ptr;
  logic        m_full;

  always #5 clk = ~clk;

  rr_mux_nx1 #(.N(8), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .rr_en     (rr_en),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check comb grant and output against the model, then advance.
  task automatic cyc();
    logic [7:0]  eg;
    int          gi;
    int          k;
    logic [15:0] front;
    #1;
    eg = 8'h00;
    gi = 0;
    if (!rst && (!m_full || out_ready)) begin
      if (rr_en) begin
        for (int i = 1; i <= 8; i++) begin
          k = (m_ptr + i) % 8;
          if (eg == 8'h00 && in_valid[k]) begin
            eg[k] = 1'b1;
            gi    = k;
          end
        end
      end else if (in_valid[sel]) begin
        eg[sel] = 1'b1;
        gi      = int'(sel);
      end
    end
    chk("in_ready", in_ready, eg);
    chk("out_valid", out_valid, m_full);
    if (m_full) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'd0, 32'd1);
      end else begin
        front = sb[0];
        chk("out_data", out_data, front[7:0]);
        chk("out_ch", out_ch, front[15:8]);
        if (out_ready) void'(sb.pop_front());
      end
    end
    if (eg != 8'h00) begin
      sb.push_back({8'(gi), in_data[gi*8 +: 8]});
      glog.push_back(gi);
      if (rr_en) m_ptr = gi;
      m_full = 1'b1;
    end else if (out_ready) begin
      m_full = 1'b0;
    end
    if (rst) begin
      sb.delete();
      m_full = 1'b0;
      m_ptr  = 7;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_ch", out_ch, 32'd0);
  endtask

  task automatic chk_glog(input string tag, input int idx, input int exp);
    chk(tag, (glog.size() > idx) ? glog[idx] : 99, exp);
  endtask

  initial begin
    rst = 1'b1; rr_en = 1'b0; sel = 3'd0; in_data = 64'd0;
    in_valid = 8'hFF; out_ready = 1'b0;
    m_full = 1'b0; m_ptr = 7;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rdy_in_rst", in_ready, 32'h00);
    @(negedge clk);
    do_reset();

    // fixed select on channel 5
    rr_en = 1'b0; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
    in_data = {$urandom, $urandom};
    in_data[47:40] = 8'hA5;
    cyc();
    chk("fix_data", out_data, 32'hA5);
    chk("fix_ch", out_ch, 32'd5);
    chk("fix_vld", out_valid, 32'd1);

    // round-robin sweep from reset
    do_reset();
    rr_en = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    glog.delete();
    for (int i = 0; i < 9; i++) begin
      in_data = {$urandom, $urandom};
      cyc();
    end
    for (int i = 0; i < 9; i++) chk_glog("rr_seq", i, i % 8);

    // backpressure while FULL
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      cyc();
    end

    // reset while FULL, then first grant is channel 0
    do_reset();
    rr_en = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
    glog.delete();
    cyc();
    chk_glog("post_rst_grant", 0, 0);

    // wrap-around with ptr=0
    in_valid = 8'b1000_0001;
    glog.delete();
    for (int i = 0; i < 3; i++) begin
      in_data = {$urandom, $urandom};
      cyc();
    end
    chk_glog("wrap0", 0, 7);
    chk_glog("wrap1", 1, 0);
    chk_glog("wrap2", 2, 7);

    // idle drain keeps ptr
    in_valid = 8'h08;
    cyc();
    in_valid = 8'h00;
    repeat (3) cyc();
    in_valid = 8'hFF;
    glog.delete();
    cyc();
    chk_glog("ptr_kept", 0, 4);

    // random mode/sel/valid/backpressure mix
    for (int i = 0; i < 60; i++) begin
      rr_en     = 1'($urandom);
      sel       = 3'($urandom);
      in_valid  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      cyc();
    end

    in_valid = 8'h00; out_ready = 1'b1;
    repeat (2) cyc();
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
